program_loader: RTL

//  Boot-time program loader sitting directly upstream of the datapath flash port.

---
 rtl/program_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: turns a length-prefixed little-endian byte stream into
// one-cycle instruction-memory writes and holds the core until the program is in.
//
// state | meaning
// IDLE  | after reset, waiting for start; core held
// LEN   | collecting the 4-byte program length
// DATA  | collecting the 4 bytes of the next instruction word
// WRITE | one-cycle flash write of the assembled word; input back-pressured
// DONE  | program complete; core released
// ERROR | length exceeded DEPTH_WORDS; core held until the next start
module program_loader #(
    parameter int          WIDTH       = 32,
    parameter int          DEPTH_WORDS = 256,
    parameter int unsigned BASE_ADDR   = 0,
    localparam int         CW          = $clog2(DEPTH_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             core_hold,
    output logic             done,
    output logic             overflow,
    output logic [CW-1:0]    word_count
);

    if (WIDTH != 32) begin : g_width_check
        $error("program_loader supports WIDTH=32 only");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [CW-1:0] len;
    logic [31:0]   n_full;
    logic [CW-1:0] wc_next;
    logic          accept;
    logic          last_byte;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = accept && (byte_idx == 2'd3);
    // The fourth byte goes straight into the word, so only three need buffering.
    assign n_full    = {byte_data, word_buf};
    assign wc_next   = word_count + CW'(1);

    assign byte_ready = (state == LEN) || (state == DATA);
    assign flash_en   = (state == WRITE);
    assign core_hold  = (state != DONE);
    assign done       = (state == DONE);
    assign overflow   = (state == ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = LEN;
            end
            LEN: begin
                if (last_byte) begin
                    if (n_full == 32'd0)                     state_next = DONE;
                    else if (n_full > 32'(DEPTH_WORDS))      state_next = ERROR;
                    else                                     state_next = DATA;
                end
            end
            DATA: begin
                if (last_byte) state_next = WRITE;
            end
            WRITE: begin
                state_next = (wc_next == len) ? DONE : DATA;
            end
            DONE, ERROR: begin
                if (start) state_next = LEN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            len        <= '0;
            word_count <= '0;
            flash_addr <= '0;
            flash_data <= '0;
        end else begin
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= byte_data;
                    2'd1: word_buf[15:8]  <= byte_data;
                    2'd2: word_buf[23:16] <= byte_data;
                    default: begin
                        if (state == LEN) begin
                            len        <= n_full[CW-1:0];
                            word_count <= '0;
                        end else begin
                            // Loaded one cycle early so the WRITE cycle presents them straight from flops.
                            flash_data <= n_full;
                            flash_addr <= WIDTH'(BASE_ADDR) + (WIDTH'(word_count) << 2);
                        end
                    end
                endcase
            end
            if (state == WRITE) begin
                word_count <= wc_next;
            end
        end
    end

endmodule
